// File: rtl/stk_pkg.sv
// rtl/stk_pkg.sv - shared opcodes, bridge codes, latencies and FSM states for the stack sequencer
package stk_pkg;

   localparam logic [3:0] OP_PUSHC = 4'd0;
   localparam logic [3:0] OP_PUSHM = 4'd1;
   localparam logic [3:0] OP_POPM  = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_AND   = 4'd5;
   localparam logic [3:0] OP_OR    = 4'd6;
   localparam logic [3:0] OP_XOR   = 4'd7;
   localparam logic [3:0] OP_JMP   = 4'd8;
   localparam logic [3:0] OP_JZ    = 4'd9;
   localparam logic [3:0] OP_HALT  = 4'd15;

   localparam logic [3:0] CB_PUSH_CONST = 4'd0;
   localparam logic [3:0] CB_LOAD_PUSH  = 4'd1;
   localparam logic [3:0] CB_POP_STORE  = 4'd2;

   localparam logic [1:0] LAT_PUSHC = 2'd2;
   localparam logic [1:0] LAT_PUSHM = 2'd3;
   localparam logic [1:0] LAT_POPM  = 2'd3;

   localparam int OPC_MSB = 11;
   localparam int OPC_LSB = 8;
   localparam int OPD_MSB = 7;
   localparam int OPD_LSB = 0;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_FETCH_W,
      ST_DECODE,
      ST_ISSUE_WB,
      ST_WAIT_WB,
      ST_ISSUE_ALU,
      ST_WAIT_ALU,
      ST_HALT
   } state_t;

endpackage

// File: rtl/stk_dec.sv
// rtl/stk_dec.sv - combinational opcode classifier and bridge latency lookup
module stk_dec
   import stk_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       is_wb,
   output logic       is_alu,
   output logic       is_jmp,
   output logic       is_jz,
   output logic       is_halt,
   output logic       is_illegal,
   output logic [1:0] lat
);

   always_comb begin
      is_wb      = 1'b0;
      is_alu     = 1'b0;
      is_jmp     = 1'b0;
      is_jz      = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      lat        = 2'd0;
      case (opcode)
         OP_PUSHC: begin
            is_wb = 1'b1;
            lat   = LAT_PUSHC;
         end
         OP_PUSHM: begin
            is_wb = 1'b1;
            lat   = LAT_PUSHM;
         end
         OP_POPM: begin
            is_wb = 1'b1;
            lat   = LAT_POPM;
         end
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_alu = 1'b1;
         OP_JMP:  is_jmp  = 1'b1;
         OP_JZ:   is_jz   = 1'b1;
         OP_HALT: is_halt = 1'b1;
         default: is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/stk_seq_ctrl.sv
// rtl/stk_seq_ctrl.sv - fetch/decode/dispatch sequencer driving the stack-memory bridge and the ALU
module stk_seq_ctrl
   import stk_pkg::*;
#(
   parameter int ADDR_LEN  = 8,
   parameter int DATA_LEN  = 8,
   parameter int INSTR_LEN = 12
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 run,
   output logic [ADDR_LEN-1:0]  imem_addr,
   output logic                 imem_r_en,
   input  logic [INSTR_LEN-1:0] imem_data,
   output logic [3:0]           control_bus,
   output logic                 en,
   output logic [DATA_LEN-1:0]  addr_const,
   output logic [2:0]           alu_op,
   output logic                 alu_start,
   input  logic                 alu_done,
   input  logic                 alu_zero,
   output logic [ADDR_LEN-1:0]  pc,
   output logic                 busy,
   output logic                 halted,
   output logic                 err
);

   state_t               state;
   logic [INSTR_LEN-1:0] ir;
   logic [1:0]           wait_cnt;
   logic [3:0]           opcode;
   logic [ADDR_LEN-1:0]  operand;
   logic [ADDR_LEN-1:0]  pc_inc;

   logic dec_wb, dec_alu, dec_jmp, dec_jz, dec_halt, dec_illegal;
   logic [1:0] dec_lat;

   assign opcode    = ir[OPC_MSB:OPC_LSB];
   assign operand   = ir[OPD_MSB:OPD_LSB];
   assign pc_inc    = pc + ADDR_LEN'(1);
   assign imem_addr = pc;

   stk_dec u_dec (
      .opcode     (opcode),
      .is_wb      (dec_wb),
      .is_alu     (dec_alu),
      .is_jmp     (dec_jmp),
      .is_jz      (dec_jz),
      .is_halt    (dec_halt),
      .is_illegal (dec_illegal),
      .lat        (dec_lat)
   );

   // Outputs are registered: each is set on the transition into the state that owns it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         pc          <= '0;
         ir          <= '0;
         wait_cnt    <= '0;
         imem_r_en   <= 1'b0;
         control_bus <= '0;
         en          <= 1'b0;
         addr_const  <= '0;
         alu_op      <= '0;
         alu_start   <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         err         <= 1'b0;
      end else begin
         imem_r_en <= 1'b0;
         en        <= 1'b0;
         alu_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (run) begin
                  state     <= ST_FETCH;
                  imem_r_en <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            ST_FETCH: state <= ST_FETCH_W;
            ST_FETCH_W: begin
               ir    <= imem_data;
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               if (dec_wb) begin
                  state       <= ST_ISSUE_WB;
                  en          <= 1'b1;
                  control_bus <= {2'b00, opcode[1:0]};
                  addr_const  <= DATA_LEN'(operand);
               end else if (dec_alu) begin
                  state     <= ST_ISSUE_ALU;
                  alu_start <= 1'b1;
                  alu_op    <= opcode[2:0];
               end else if (dec_jmp) begin
                  pc        <= operand;
                  state     <= ST_FETCH;
                  imem_r_en <= 1'b1;
               end else if (dec_jz) begin
                  pc        <= alu_zero ? operand : pc_inc;
                  state     <= ST_FETCH;
                  imem_r_en <= 1'b1;
               end else begin
                  state  <= ST_HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
                  if (dec_illegal || !dec_halt)
                     err <= 1'b1;
               end
            end
            ST_ISSUE_WB: begin
               wait_cnt <= dec_lat;
               state    <= ST_WAIT_WB;
            end
            // Bridge resamples its opcode while waiting, so control_bus/addr_const hold here.
            ST_WAIT_WB: begin
               if (wait_cnt == 2'd1) begin
                  pc          <= pc_inc;
                  state       <= ST_FETCH;
                  imem_r_en   <= 1'b1;
                  control_bus <= '0;
                  addr_const  <= '0;
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            ST_ISSUE_ALU: state <= ST_WAIT_ALU;
            ST_WAIT_ALU: begin
               if (alu_done) begin
                  pc        <= pc_inc;
                  state     <= ST_FETCH;
                  imem_r_en <= 1'b1;
                  alu_op    <= '0;
               end
            end
            ST_HALT: state <= ST_HALT;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
